// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage data-memory controller: funct3 encodings,
// FSM states and the access legality / alignment rules.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Stores only exist in signed-agnostic B/H/W forms; loads also allow BU/HU.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_H, F3_HU: bad = addr_lo[0];
      F3_W:        bad = (addr_lo != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] addr_lo);
    return funct3_legal(is_store, f3) & ~misaligned(f3, addr_lo);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data replication and byte enables,
// and load lane selection with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] ld_ext
);

  logic [31:0] ld_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wdata = st_data;
    st_be    = 4'b1111;
    case (st_funct3)
      F3_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_be    = 4'b0001 << st_addr_lo;
      end
      F3_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = st_data;
        st_be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_shifted = ld_word >> {ld_addr_lo, 3'b000};
    ld_byte    = ld_shifted[7:0];
    ld_half    = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_funct3)
      F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_ext = {24'h000000, ld_byte};
      F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_ext = {16'h0000, ld_half};
      default: ld_ext = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// M-stage data-memory controller: accepts a load/store from the pipeline register,
// runs one req/ack bus transaction with timeout, and stalls the pipeline until done.
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              M_valid,
  input  logic              M_read,
  input  logic              M_write,
  input  logic [2:0]        M_funct3,
  input  logic [ADDR_W-1:0] M_addr,
  input  logic [DATA_W-1:0] M_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_e  state;
  logic [7:0]  wait_cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        start;
  logic        start_ok;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_ext;

  mem_lane_align u_align (
    .st_funct3  (M_funct3),
    .st_addr_lo (M_addr[1:0]),
    .st_data    (M_wdata),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_lo_q),
    .ld_word    (bus_rdata),
    .st_wdata   (st_wdata),
    .st_be      (st_be),
    .ld_ext     (ld_ext)
  );

  // Stall must reach the pipeline in the accept cycle itself, so it is combinational.
  always_comb begin
    start    = M_valid & (M_read | M_write);
    start_ok = access_ok(M_write, M_funct3, M_addr[1:0]);
    stall    = ((state == ST_IDLE) & start) | (state == ST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 8'd0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      ld_data   <= '0;
      ld_valid  <= 1'b0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= 4'b0000;
    end else begin
      ld_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (start_ok) begin
              bus_addr  <= {M_addr[ADDR_W-1:2], 2'b00};
              bus_we    <= M_write;
              bus_wdata <= st_wdata;
              bus_be    <= M_write ? st_be : 4'b1111;
              funct3_q  <= M_funct3;
              addr_lo_q <= M_addr[1:0];
              bus_req   <= 1'b1;
              wait_cnt  <= 8'd0;
              state     <= ST_WAIT;
            end else begin
              ld_data  <= '0;
              ld_valid <= 1'b1;
              err      <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        // An ack arriving on the last permitted cycle still completes normally.
        ST_WAIT: begin
          if (bus_ack) begin
            ld_data  <= bus_we ? '0 : ld_ext;
            ld_valid <= 1'b1;
            bus_req  <= 1'b0;
            state    <= ST_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            ld_data  <= '0;
            ld_valid <= 1'b1;
            err      <= 1'b1;
            bus_req  <= 1'b0;
            state    <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized self-checking bench for mem_stage_ctrl against a transaction-level
// model of the access timeline, plus directed literal checks.
module tb_mem_stage_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        M_valid, M_read, M_write;
  logic [2:0]  M_funct3;
  logic [31:0] M_addr, M_wdata;
  logic        stall, ld_valid, err, bus_req, bus_we, bus_ack;
  logic [31:0] ld_data, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  mem_stage_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .M_valid(M_valid), .M_read(M_read), .M_write(M_write),
    .M_funct3(M_funct3), .M_addr(M_addr), .M_wdata(M_wdata), .stall(stall),
    .ld_data(ld_data), .ld_valid(ld_valid), .err(err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit          exp_en = 0;
  bit          exp_stall, exp_req, exp_ldv, exp_err, chk_bus, chk_reset;
  logic [31:0] exp_ldd, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  bit          exp_we;

  int          stall_cnt = 0;
  int          req_cnt   = 0;
  logic [31:0] last_ld   = '0;
  logic        last_err  = 1'b0;
  logic [3:0]  seen_be   = '0;
  logic [31:0] seen_wdata = '0;
  logic [31:0] seen_addr  = '0;
  logic        seen_we    = 1'b0;

  // Spec-level model: access size in bytes, 0 for an encoding that is not allowed.
  function automatic bit modelLegal(bit wr, logic [2:0] f3, logic [1:0] lo);
    int size;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: size = wr ? 0 : 1;
      3'd5: size = wr ? 0 : 2;
      default: size = 0;
    endcase
    if (size == 0) return 1'b0;
    return (int'(lo) % size) == 0;
  endfunction

  function automatic logic [31:0] modelLoad(logic [2:0] f3, logic [1:0] lo, logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * int'(lo))) & 32'hFF;
    h = (rd >> (16 * (int'(lo) / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'd4: return b;
      3'd1: return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'd5: return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] modelBe(bit wr, logic [2:0] f3, logic [1:0] lo);
    if (!wr) return 4'hF;
    case (f3)
      3'd0: return 4'(1 << int'(lo));
      3'd1: return 4'(3 << int'(lo));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] modelWdata(logic [2:0] f3, logic [31:0] wd);
    case (f3)
      3'd0: return (wd & 32'hFF) * 32'h01010101;
      3'd1: return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  task automatic checkOutput();
    cmp("stall", 32'(stall), 32'(exp_stall));
    cmp("bus_req", 32'(bus_req), 32'(exp_req));
    cmp("ld_valid", 32'(ld_valid), 32'(exp_ldv));
    cmp("err", 32'(err), 32'(exp_err));
    if (exp_ldv) cmp("ld_data", ld_data, exp_ldd);
    if (chk_bus) begin
      cmp("bus_we", 32'(bus_we), 32'(exp_we));
      cmp("bus_addr", bus_addr, exp_addr);
      cmp("bus_be", 32'(bus_be), 32'(exp_be));
      if (exp_we) cmp("bus_wdata", bus_wdata, exp_wdata);
    end
    if (chk_reset) begin
      cmp("rst_ld_data", ld_data, 32'h0);
      cmp("rst_bus_addr", bus_addr, 32'h0);
      cmp("rst_bus_wdata", bus_wdata, 32'h0);
      cmp("rst_bus_be", 32'(bus_be), 32'h0);
      cmp("rst_bus_we", 32'(bus_we), 32'h0);
    end
  endtask

  // Single compare process; also records what the DUT showed for directed literal checks.
  always @(negedge clk) begin
    if (exp_en) checkOutput();
    if (stall) stall_cnt <= stall_cnt + 1;
    if (bus_req) begin
      req_cnt    <= req_cnt + 1;
      seen_be    <= bus_be;
      seen_wdata <= bus_wdata;
      seen_addr  <= bus_addr;
      seen_we    <= bus_we;
    end
    if (ld_valid) begin
      last_ld  <= ld_data;
      last_err <= err;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setExp(bit s, bit r, bit v, bit e, logic [31:0] d);
    exp_en = 1; exp_stall = s; exp_req = r; exp_ldv = v; exp_err = e; exp_ldd = d;
    chk_bus = 0; chk_reset = 0;
  endtask

  task automatic idleCycles(int n, bit noise);
    for (int i = 0; i < n; i++) begin
      nextCycle();
      M_valid = noise ? 1'($urandom % 2) : 1'b0;
      M_read = 0; M_write = 0; M_addr = $urandom; M_funct3 = 3'($urandom);
      bus_ack = noise ? 1'($urandom % 2) : 1'b0;
      setExp(0, 0, 0, 0, '0);
    end
  endtask

  // One complete instruction through M; ack_at = req cycle carrying ack (0 or >TO = never).
  task automatic applyStimulus(bit wr, bit rd_also, logic [2:0] f3, logic [31:0] addr,
                               logic [31:0] wd, logic [31:0] rd, int ack_at);
    bit legal, timed_out;
    legal = modelLegal(wr, f3, addr[1:0]);
    nextCycle();
    M_valid = 1; M_write = wr; M_read = wr ? rd_also : 1'b1;
    M_funct3 = f3; M_addr = addr; M_wdata = wd; bus_ack = 0;
    setExp(1, 0, 0, 0, '0);
    if (!legal) begin
      nextCycle();
      bus_ack = 0;
      setExp(0, 0, 1, 1, 32'h0);
    end else begin
      timed_out = 1;
      for (int i = 1; i <= TO; i++) begin
        nextCycle();
        bus_ack   = (i == ack_at);
        bus_rdata = (i == ack_at) ? rd : $urandom;
        setExp(1, 1, 0, 0, '0);
        chk_bus = 1; exp_we = wr; exp_addr = addr & 32'hFFFFFFFC;
        exp_be = modelBe(wr, f3, addr[1:0]); exp_wdata = modelWdata(f3, wd);
        if (i == ack_at) begin
          timed_out = 0;
          break;
        end
      end
      nextCycle();
      bus_ack = 0;
      setExp(0, 0, 1, timed_out, (timed_out || wr) ? 32'h0 : modelLoad(f3, addr[1:0], rd));
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0, r0;
    logic [2:0] f3;
    logic [2:0] f3_tab [5];
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
    f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;
    rst = 1; M_valid = 0; M_read = 0; M_write = 0; M_funct3 = 0;
    M_addr = 0; M_wdata = 0; bus_ack = 0; bus_rdata = 0;
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      setExp(0, 0, 0, 0, '0);
      chk_reset = 1;
    end
    nextCycle();
    rst = 0;
    setExp(0, 0, 0, 0, '0);

    // LW 0x100, ack on third req cycle
    s0 = stall_cnt;
    applyStimulus(0, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    idleCycles(1, 0);
    cmp("lw_ld_data", last_ld, 32'hDEADBEEF);
    cmp("lw_stall_cycles", 32'(stall_cnt - s0), 32'd4);

    applyStimulus(0, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1);
    idleCycles(1, 0);
    cmp("lb_ld_data", last_ld, 32'hFFFFFF80);
    applyStimulus(0, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 2);
    idleCycles(1, 0);
    cmp("lbu_ld_data", last_ld, 32'h00000080);
    applyStimulus(0, 0, 3'b101, 32'h102, 32'h0, 32'h80112233, 1);
    idleCycles(1, 0);
    cmp("lhu_ld_data", last_ld, 32'h00008011);

    applyStimulus(1, 0, 3'b000, 32'h201, 32'h000000A5, 32'h0, 2);
    idleCycles(1, 0);
    cmp("sb_we", 32'(seen_we), 32'd1);
    cmp("sb_be", 32'(seen_be), 32'h2);
    cmp("sb_wdata", seen_wdata, 32'hA5A5A5A5);
    cmp("sb_addr", seen_addr, 32'h200);

    // Misaligned LW: no bus cycle, one stall cycle, error pulse
    s0 = stall_cnt; r0 = req_cnt;
    applyStimulus(0, 0, 3'b010, 32'h102, 32'h0, 32'h0, 1);
    idleCycles(1, 0);
    cmp("misal_req_cycles", 32'(req_cnt - r0), 32'd0);
    cmp("misal_stall_cycles", 32'(stall_cnt - s0), 32'd1);
    cmp("misal_err", 32'(last_err), 32'd1);
    cmp("misal_ld_data", last_ld, 32'h0);

    // Never acked: request held TO cycles then aborted
    r0 = req_cnt;
    applyStimulus(0, 0, 3'b010, 32'h400, 32'h0, 32'h12345678, 0);
    idleCycles(1, 0);
    cmp("timeout_req_cycles", 32'(req_cnt - r0), 32'(TO));
    cmp("timeout_err", 32'(last_err), 32'd1);
    cmp("timeout_ld_data", last_ld, 32'h0);

    // Ack on the very last permitted cycle completes without error
    applyStimulus(0, 0, 3'b010, 32'h500, 32'h0, 32'hCAFEF00D, TO);
    idleCycles(1, 0);
    cmp("ack_at_limit_err", 32'(last_err), 32'd0);
    cmp("ack_at_limit_data", last_ld, 32'hCAFEF00D);

    // Reset while waiting, then a late ack that must be ignored
    nextCycle();
    M_valid = 1; M_read = 1; M_write = 0; M_funct3 = 3'b010; M_addr = 32'h300; bus_ack = 0;
    setExp(1, 0, 0, 0, '0);
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      rst = (i == 1);
      setExp(1, 1, 0, 0, '0);
    end
    nextCycle();
    rst = 0; M_valid = 0; M_read = 0; bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
    setExp(0, 0, 0, 0, '0);
    chk_reset = 1;
    nextCycle();
    setExp(0, 0, 0, 0, '0);
    idleCycles(1, 0);

    for (int t = 0; t < 150; t++) begin
      bit wr;
      logic [31:0] a;
      wr = 1'($urandom % 2);
      f3 = ($urandom % 6 == 0) ? 3'($urandom) : f3_tab[$urandom % 5];
      a  = $urandom;
      if ($urandom % 3 != 0) a[1:0] = 2'b00;
      applyStimulus(wr, 1'($urandom % 2), f3, a, $urandom, $urandom,
                    int'($urandom_range(0, TO + 2)));
      idleCycles(int'($urandom_range(0, 2)), 1);
    end

    idleCycles(1, 0);
    @(negedge clk);
    #1;
    exp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
